go_scan: RTL and testbench
==========================

GO_SCAN -- requirements
Module: go_scan

Interface
REQ-001 Parameter N, default 3, board side length (N >= 3, N <= 8).
REQ-002 Parameter K, default 3, run length required to win (3 <= K <= N).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  request a scan; sampled only in IDLE.
REQ-006 board  input  2*N*N  cell (r,c) at bits [2i+1:2i], i=r*N+c; bit 2i = P1 mark, bit 2i+1 = P2 mark.
REQ-007 busy  output  1  high in SCAN.
REQ-008 done  output  1  one-cycle pulse: result valid.
REQ-009 win  output  1  a K-run was found.
REQ-010 winner  output  1  0 = P1, 1 = P2; valid when win=1.
REQ-011 line_row, line_col  output  max(1,$clog2(N)) each  start cell of the winning run.
REQ-012 line_dir  output  2  0 = right, 1 = down, 2 = down-right, 3 = down-left.
REQ-013 draw  output  1  board full, no win (see Configuration).
REQ-014 err  output  1  some cell had both bits set.

Function
REQ-015 FSM states IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE on hit/err/last cell, DONE->IDLE unconditionally.
REQ-016 On the start-accept cycle s, board is copied to an internal snapshot; later board changes do not affect the scan.
REQ-017 SCAN examines one cell index i per cycle, i = 0..N*N-1 in raster order, at cycle s+1+i.
REQ-018 Per cell: all 4 directions evaluated in parallel, P1 and P2 both; runs leaving the board are not counted.
REQ-019 Priority at a cell: err > P1 > P2; among directions, lowest line_dir wins.
REQ-020 Hit at index i: done pulses at cycle s+2+i, win=1, winner/line_row/line_col/line_dir latched.
REQ-021 err at index i: done pulses at s+2+i, err=1, win=0; scan terminates.
REQ-022 No hit: done pulses at s+1+N*N with win=0, err=0.
REQ-023 Result outputs are registered, updated only with done, held until the next done; busy=0 when done=1.
REQ-024 start while busy or in DONE is ignored (no queueing).
REQ-025 Index counter is $clog2(N*N) bits wide; does not wrap past N*N-1.

Reset
REQ-026 resetn=0 on a clock edge: FSM->IDLE, counter=0, busy=done=win=winner=draw=err=0, line_row=line_col=line_dir=0.
REQ-027 Reset mid-SCAN aborts the scan; no done pulse is produced for it.

Configuration
REQ-028 Macro GO_SCAN_DRAW_EN: when defined, draw=1 with done if no hit, no err, and every cell has exactly one bit set; when undefined, draw is tied to 0 and no fullness logic exists.

Structure
REQ-029 Shared package go_pkg holds the direction enum (DIR_RIGHT..DIR_DLEFT), FSM state typedef and player constants P1=0, P2=1.
REQ-030 Sub-module go_cell_check (combinational): inputs snapshot, cell index; outputs hit, winner, dir, err per REQ-018/019.

Verification
REQ-031 N=3,K=3, board=0x15 (P1 top row), start at s -> done at s+2, win=1, winner=0, row=0, col=0, dir=0.
REQ-032 N=3, board=0x2220 (P2 anti-diagonal) -> done at s+4 (index 2), win=1, winner=1, row=0, col=2, dir=3.
REQ-033 N=3, board=0x0 -> done at s+10, win=0, err=0, draw=0.
REQ-034 N=3, board=0x3 (cell 0 both bits) -> done at s+2, err=1, win=0.
REQ-035 N=3, full board X O X / X O O / O X X with GO_SCAN_DRAW_EN -> done at s+10, draw=1; without macro draw=0.
REQ-036 N=5,K=4, P1 cells (1,1),(2,2),(3,3),(4,4); resetn low at s+3 -> no done; rerun -> done at s+8, row=1, col=1, dir=2.

Source files
------------

// File: rtl/go_scan_pkg.sv
// Shared types and constants for the tic-tac-toe / gomoku style line scanner.
// Holds the run direction enum, FSM state type, player encodings and helpers.
package go_pkg;

  // Direction a winning run extends from its start cell
  typedef enum logic [1:0] {
    DIR_RIGHT  = 2'd0,
    DIR_DOWN   = 2'd1,
    DIR_DRIGHT = 2'd2,
    DIR_DLEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Width of a row/column coordinate for an n x n board (at least one bit)
  function automatic int coord_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Lowest-numbered direction whose bit is set in the mask
  function automatic dir_e first_dir(input logic [3:0] m);
    dir_e d;
    casez (m)
      4'b???1: d = DIR_RIGHT;
      4'b??10: d = DIR_DOWN;
      4'b?100: d = DIR_DRIGHT;
      default: d = DIR_DLEFT;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/go_scan_if.sv
// Request/result bundle between a scan requester and the go_scan engine.
interface go_scan_if
  import go_pkg::*;
#(
  parameter int N = 3
);
  localparam int LW = coord_w(N);

  logic              start;
  logic [2*N*N-1:0]  board;
  logic              busy;
  logic              done;
  logic              win;
  logic              winner;
  logic [LW-1:0]     line_row;
  logic [LW-1:0]     line_col;
  logic [1:0]        line_dir;
  logic              draw;
  logic              err;

  modport master (
    output start, board,
    input  busy, done, win, winner, line_row, line_col, line_dir, draw, err
  );

  modport slave (
    input  start, board,
    output busy, done, win, winner, line_row, line_col, line_dir, draw, err
  );

endinterface

// File: rtl/go_scan_cell_check.sv
// Combinational evaluation of one start cell: checks all four directions for
// a K-long run of either player, plus the double-marked-cell error condition.
module go_cell_check
  import go_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int IW = 4
) (
  input  logic [2*N*N-1:0] snap,
  input  logic [IW-1:0]    idx,
  output logic             hit,
  output logic             winner,
  output dir_e             dir,
  output logic             err
);

  int row;
  int col;
  logic [3:0] run_p1;
  logic [3:0] run_p2;

  // Split the raster index into board coordinates
  always_comb begin
    row = int'(idx) / N;
    col = int'(idx) % N;
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      localparam int DR = (gi == 0) ? 0 : 1;
      localparam int DC = (gi == 0) ? 1 : (gi == 1) ? 0 : (gi == 2) ? 1 : -1;
      logic p1_ok;
      logic p2_ok;

      // Walk K cells from the start cell; a run that leaves the board never counts
      always_comb begin
        int r;
        int c;
        logic in_b;
        in_b  = 1'b1;
        p1_ok = 1'b1;
        p2_ok = 1'b1;
        for (int k = 0; k < K; k++) begin
          r = row + k * DR;
          c = col + k * DC;
          if (r < 0 || r >= N || c < 0 || c >= N) begin
            in_b = 1'b0;
          end else begin
            p1_ok = p1_ok & snap[2*(r*N+c)];
            p2_ok = p2_ok & snap[2*(r*N+c)+1];
          end
        end
        p1_ok = p1_ok & in_b;
        p2_ok = p2_ok & in_b;
      end

      assign run_p1[gi] = p1_ok;
      assign run_p2[gi] = p2_ok;
    end
  endgenerate

  // Resolve priority: a corrupt cell beats any run, P1 beats P2, low dir first
  always_comb begin
    int cur;
    cur    = int'(idx);
    err    = snap[2*cur] & snap[2*cur+1];
    hit    = 1'b0;
    winner = P1;
    dir    = DIR_RIGHT;
    if (!err) begin
      if (|run_p1) begin
        hit    = 1'b1;
        winner = P1;
        dir    = first_dir(run_p1);
      end else if (|run_p2) begin
        hit    = 1'b1;
        winner = P2;
        dir    = first_dir(run_p2);
      end
    end
  end

endmodule

// File: rtl/go_scan.sv
// Sequential board scanner: snapshots the board on start, examines one start
// cell per cycle in raster order and reports the first winning run or error.
// Optional feature: define GO_SCAN_DRAW_EN to report a full board with no win.
module go_scan
  import go_pkg::*;
#(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic     clk,
  input  logic     resetn,
  go_scan_if.slave bus
);

  localparam int IW = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int LW = coord_w(N);
  localparam logic [IW-1:0] LAST = IW'(N * N - 1);

  state_e           state_reg;
  logic [IW-1:0]    idx_reg;
  logic [2*N*N-1:0] snap_reg;

  // Result captured when the scan ends, published one cycle later with done
  logic             pend_hit_reg;
  logic             pend_err_reg;
  logic             pend_winner_reg;
  dir_e             pend_dir_reg;
  logic [LW-1:0]    pend_row_reg;
  logic [LW-1:0]    pend_col_reg;

  logic             busy_reg;
  logic             done_reg;
  logic             win_reg;
  logic             winner_reg;
  logic             err_reg;
  dir_e             dir_reg;
  logic [LW-1:0]    row_reg;
  logic [LW-1:0]    col_reg;

  logic             chk_hit;
  logic             chk_winner;
  dir_e             chk_dir;
  logic             chk_err;
  logic [LW-1:0]    cur_row;
  logic [LW-1:0]    cur_col;
  logic             scan_end;

  go_cell_check #(.N(N), .K(K), .IW(IW)) u_check (
    .snap   (snap_reg),
    .idx    (idx_reg),
    .hit    (chk_hit),
    .winner (chk_winner),
    .dir    (chk_dir),
    .err    (chk_err)
  );

  // Coordinates of the cell under examination and the scan-termination test
  always_comb begin
    cur_row  = LW'(int'(idx_reg) / N);
    cur_col  = LW'(int'(idx_reg) % N);
    scan_end = (state_reg == ST_SCAN) && (chk_hit || chk_err || idx_reg == LAST);
  end

  // Main controller: IDLE -> SCAN -> DONE -> IDLE with registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      snap_reg        <= '0;
      pend_hit_reg    <= 1'b0;
      pend_err_reg    <= 1'b0;
      pend_winner_reg <= P1;
      pend_dir_reg    <= DIR_RIGHT;
      pend_row_reg    <= '0;
      pend_col_reg    <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      win_reg         <= 1'b0;
      winner_reg      <= P1;
      err_reg         <= 1'b0;
      dir_reg         <= DIR_RIGHT;
      row_reg         <= '0;
      col_reg         <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            snap_reg  <= bus.board;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_end) begin
            pend_hit_reg    <= chk_hit;
            pend_err_reg    <= chk_err;
            pend_winner_reg <= chk_hit ? chk_winner : P1;
            pend_dir_reg    <= chk_hit ? chk_dir : DIR_RIGHT;
            pend_row_reg    <= chk_hit ? cur_row : '0;
            pend_col_reg    <= chk_hit ? cur_col : '0;
            busy_reg        <= 1'b0;
            state_reg       <= ST_DONE;
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        ST_DONE: begin
          done_reg   <= 1'b1;
          win_reg    <= pend_hit_reg;
          err_reg    <= pend_err_reg;
          winner_reg <= pend_winner_reg;
          dir_reg    <= pend_dir_reg;
          row_reg    <= pend_row_reg;
          col_reg    <= pend_col_reg;
          idx_reg    <= '0;
          state_reg  <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GO_SCAN_DRAW_EN
  logic [N*N-1:0] cell_one;
  logic           board_full;
  logic           pend_draw_reg;
  logic           draw_reg;

  generate
    for (genvar gi = 0; gi < N * N; gi++) begin : g_full
      assign cell_one[gi] = snap_reg[2*gi] ^ snap_reg[2*gi+1];
    end
  endgenerate

  assign board_full = &cell_one;

  // Draw flag follows the same capture/publish timing as the other results
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_draw_reg <= 1'b0;
      draw_reg      <= 1'b0;
    end else begin
      if (scan_end) begin
        pend_draw_reg <= board_full & ~chk_hit & ~chk_err;
      end
      if (state_reg == ST_DONE) begin
        draw_reg <= pend_draw_reg;
      end
    end
  end

  assign bus.draw = draw_reg;
`else
  assign bus.draw = 1'b0;
`endif

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.win      = win_reg;
  assign bus.winner   = winner_reg;
  assign bus.err      = err_reg;
  assign bus.line_dir = dir_reg;
  assign bus.line_row = row_reg;
  assign bus.line_col = col_reg;

endmodule

// File: tb/tb_go_scan.sv
// Directed bench for go_scan: a 3x3/K=3 and a 5x5/K=4 instance share one clock.
// Expected results are queued when a scan is launched and checked on done.
module tb_go_scan;
  import go_pkg::*;

  logic clk;
  logic resetn;
  int   cyc;
  int   s_cyc;
  int   checks;
  int   passed;

  go_scan_if #(.N(3)) if3 ();
  go_scan_if #(.N(5)) if5 ();

  go_scan #(.N(3), .K(3)) u3 (.clk(clk), .resetn(resetn), .bus(if3.slave));
  go_scan #(.N(5), .K(4)) u5 (.clk(clk), .resetn(resetn), .bus(if5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string tag;
    int    lat;
    logic  win;
    logic  err;
    logic  winner;
    logic  draw;
    int    row;
    int    col;
    int    dir;
  } exp_t;

  typedef struct {
    logic done;
    logic busy;
    logic win;
    logic err;
    logic winner;
    logic draw;
    int   row;
    int   col;
    int   dir;
  } obs_t;

  exp_t sbq[$];

  function automatic obs_t sample(input int which);
    obs_t o;
    if (which == 0) begin
      o.done = if3.done; o.busy = if3.busy; o.win = if3.win; o.err = if3.err;
      o.winner = if3.winner; o.draw = if3.draw;
      o.row = int'(if3.line_row); o.col = int'(if3.line_col); o.dir = int'(if3.line_dir);
    end else begin
      o.done = if5.done; o.busy = if5.busy; o.win = if5.win; o.err = if5.err;
      o.winner = if5.winner; o.draw = if5.draw;
      o.row = int'(if5.line_row); o.col = int'(if5.line_col); o.dir = int'(if5.line_dir);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a board with start for one cycle; s_cyc marks the accept edge
  task automatic launch(input int which, input logic [49:0] brd);
    @(negedge clk);
    if (which == 0) begin
      if3.board = brd[17:0];
      if3.start = 1'b1;
    end else begin
      if5.board = brd;
      if5.start = 1'b1;
    end
    @(posedge clk);
    #1;
    s_cyc = cyc;
    @(negedge clk);
    if3.start = 1'b0;
    if5.start = 1'b0;
  endtask

  // Wait (bounded) for done, then pop the expected entry and compare
  task automatic collect(input int which);
    obs_t o;
    exp_t e;
    bit   seen;
    int   lat;
    seen = 1'b0;
    lat  = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(posedge clk);
      #1;
      o = sample(which);
      if (o.done) begin
        seen = 1'b1;
        lat  = cyc - s_cyc;
      end
    end
    e = sbq.pop_front();
    chk({e.tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      $display("scan %s: latency=%0d win=%0b winner=%0b row=%0d col=%0d dir=%0d err=%0b draw=%0b",
               e.tag, lat, o.win, o.winner, o.row, o.col, o.dir, o.err, o.draw);
      chk({e.tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({e.tag, " busy"}, 32'(o.busy), 32'd0);
      chk({e.tag, " win"}, 32'(o.win), 32'(e.win));
      chk({e.tag, " err"}, 32'(o.err), 32'(e.err));
      chk({e.tag, " draw"}, 32'(o.draw), 32'(e.draw));
      if (e.win) begin
        chk({e.tag, " winner"}, 32'(o.winner), 32'(e.winner));
        chk({e.tag, " row"}, 32'(o.row), 32'(e.row));
        chk({e.tag, " col"}, 32'(o.col), 32'(e.col));
        chk({e.tag, " dir"}, 32'(o.dir), 32'(e.dir));
      end
    end
  endtask

  function automatic exp_t mk(input string tag, input int lat, input logic win, input logic err,
                              input logic winner, input logic draw, input int row, input int col,
                              input int dir);
    exp_t e;
    e.tag = tag; e.lat = lat; e.win = win; e.err = err; e.winner = winner;
    e.draw = draw; e.row = row; e.col = col; e.dir = dir;
    return e;
  endfunction

  initial begin
    obs_t        o;
    logic [49:0] b5;
    logic        exp_draw;
    int          ndone;

    checks = 0;
    passed = 0;
    cyc    = 0;
    resetn = 1'b0;
    if3.start = 1'b0; if3.board = '0;
    if5.start = 1'b0; if5.board = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Reset state of both instances
    o = sample(0);
    chk("rst3 busy", 32'(o.busy), 32'd0);
    chk("rst3 done", 32'(o.done), 32'd0);
    chk("rst3 win", 32'(o.win), 32'd0);
    chk("rst3 err", 32'(o.err), 32'd0);
    chk("rst3 draw", 32'(o.draw), 32'd0);
    chk("rst3 line", 32'({o.row[3:0], o.col[3:0], o.dir[1:0], o.winner}), 32'd0);
    o = sample(1);
    chk("rst5 busy", 32'(o.busy), 32'd0);
    chk("rst5 done", 32'(o.done), 32'd0);

    // P1 top row: hit at cell 0, direction right
    sbq.push_back(mk("p1_row", 2, 1'b1, 1'b0, P1, 1'b0, 0, 0, 0));
    launch(0, 50'h15);
    collect(0);

    // Result stays put after the done pulse
    repeat (3) @(posedge clk);
    #1;
    o = sample(0);
    chk("hold win", 32'(o.win), 32'd1);
    chk("hold done", 32'(o.done), 32'd0);

    // P2 anti-diagonal starting at (0,2)
    sbq.push_back(mk("p2_anti", 4, 1'b1, 1'b0, P2, 1'b0, 0, 2, 3));
    launch(0, 50'h2220);
    collect(0);

    // Empty board runs the full length; board change and start while busy ignored
    sbq.push_back(mk("empty", 10, 1'b0, 1'b0, P1, 1'b0, 0, 0, 0));
    launch(0, 50'h0);
    o = sample(0);
    chk("empty busy", 32'(o.busy), 32'd1);
    if3.board = 18'h15;
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    collect(0);
    ndone = 0;
    for (int t = 0; t < 14; t++) begin
      @(posedge clk);
      #1;
      if (if3.done) ndone++;
    end
    chk("no_requeue done", 32'(ndone), 32'd0);

    // Doubly marked cell 0
    sbq.push_back(mk("err0", 2, 1'b0, 1'b1, P1, 1'b0, 0, 0, 0));
    launch(0, 50'h3);
    collect(0);

    // Full board with no winner
`ifdef GO_SCAN_DRAW_EN
    exp_draw = 1'b1;
`else
    exp_draw = 1'b0;
`endif
    sbq.push_back(mk("full", 10, 1'b0, 1'b0, P1, exp_draw, 0, 0, 0));
    launch(0, 50'h16A59);
    collect(0);

    // 5x5, K=4 diagonal from (1,1); reset mid-scan then rerun
    b5 = '0;
    b5[2*6]  = 1'b1;
    b5[2*12] = 1'b1;
    b5[2*18] = 1'b1;
    b5[2*24] = 1'b1;
    launch(1, b5);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    o = sample(1);
    chk("abort busy", 32'(o.busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ndone = 0;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk);
      #1;
      if (if5.done) ndone++;
    end
    chk("abort done", 32'(ndone), 32'd0);
    $display("scan abort5: reset mid-scan, done pulses=%0d", ndone);

    sbq.push_back(mk("diag5", 8, 1'b1, 1'b0, P1, 1'b0, 1, 1, 2));
    launch(1, b5);
    collect(1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
